// File: rtl/riscv_pkg.sv
// riscv_pkg: shared widths, ALU/operand-select/forwarding encodings and the ID/EX register layout.
package riscv_pkg;

    localparam int XLEN   = 32;
    localparam int REG_AW = 5;

    typedef enum logic [3:0] {
        ALU_ADD  = 4'd0,
        ALU_SUB  = 4'd1,
        ALU_AND  = 4'd2,
        ALU_OR   = 4'd3,
        ALU_XOR  = 4'd4,
        ALU_SLT  = 4'd5,
        ALU_SLTU = 4'd6,
        ALU_SLL  = 4'd7,
        ALU_SRL  = 4'd8,
        ALU_SRA  = 4'd9
    } alu_op_t;

    typedef enum logic [1:0] {
        SRC_A_RS1  = 2'b00,
        SRC_A_PC   = 2'b01,
        SRC_A_ZERO = 2'b10
    } src_a_sel_t;

    typedef enum logic [1:0] {
        FWD_REG = 2'd0,
        FWD_MEM = 2'd1,
        FWD_WB  = 2'd2
    } fwd_sel_t;

    // src_a_sel kept as raw bits so the reserved 2'b11 code survives into EX and reads as zero
    typedef struct packed {
        logic              valid;
        logic [XLEN-1:0]   pc;
        logic [REG_AW-1:0] rs1_addr;
        logic [REG_AW-1:0] rs2_addr;
        logic [XLEN-1:0]   rs1_data;
        logic [XLEN-1:0]   rs2_data;
        logic [XLEN-1:0]   imm;
        alu_op_t           alu_op;
        logic [1:0]        src_a_sel;
        logic              src_b_sel;
        logic [REG_AW-1:0] rd_addr;
        logic              reg_write;
    } id_ex_t;

endpackage

// File: rtl/riscv_fwd_unit.sv
// riscv_fwd_unit: per-source operand forwarding from MEM/WB; MEM has priority and x0 is never forwarded.
// Forwarding is compiled in only when RISCV_EX_FORWARD_EN is defined; otherwise the regfile value passes through.
module riscv_fwd_unit
    import riscv_pkg::*;
(
    input  logic [REG_AW-1:0] addr,
    input  logic [XLEN-1:0]   reg_data,
    input  logic [REG_AW-1:0] mem_rd_addr,
    input  logic              mem_reg_write,
    input  logic [XLEN-1:0]   mem_result,
    input  logic [REG_AW-1:0] wb_rd_addr,
    input  logic              wb_reg_write,
    input  logic [XLEN-1:0]   wb_result,
    output fwd_sel_t          sel,
    output logic [XLEN-1:0]   value
);

`ifdef RISCV_EX_FORWARD_EN
    logic nonzero;

    assign nonzero = addr != '0;
    assign sel = (nonzero && mem_reg_write && mem_rd_addr == addr) ? FWD_MEM :
                 (nonzero && wb_reg_write  && wb_rd_addr  == addr) ? FWD_WB  : FWD_REG;
`else
    logic unused_taps;

    assign unused_taps = ^{addr, mem_rd_addr, mem_reg_write, mem_result, wb_rd_addr, wb_reg_write, wb_result};
    assign sel = FWD_REG;
`endif

    assign value = (sel == FWD_MEM) ? mem_result :
                   (sel == FWD_WB)  ? wb_result  : reg_data;

endmodule

// File: rtl/riscv_id_ex_stage.sv
// riscv_id_ex_stage: ID/EX pipeline register with operand forwarding and ALU operand selection.
// Forwarding from MEM/WB is enabled by defining RISCV_EX_FORWARD_EN.
module riscv_id_ex_stage
    import riscv_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              id_valid,
    output logic              id_ready,
    input  logic [XLEN-1:0]   id_pc,
    input  logic [REG_AW-1:0] id_rs1_addr,
    input  logic [REG_AW-1:0] id_rs2_addr,
    input  logic [XLEN-1:0]   id_rs1_data,
    input  logic [XLEN-1:0]   id_rs2_data,
    input  logic [XLEN-1:0]   id_imm,
    input  logic [3:0]        id_alu_op,
    input  logic [1:0]        id_src_a_sel,
    input  logic              id_src_b_sel,
    input  logic [REG_AW-1:0] id_rd_addr,
    input  logic              id_reg_write,
    input  logic              flush,
    input  logic              ex_stall,
    input  logic [REG_AW-1:0] mem_rd_addr,
    input  logic              mem_reg_write,
    input  logic [XLEN-1:0]   mem_result,
    input  logic [REG_AW-1:0] wb_rd_addr,
    input  logic              wb_reg_write,
    input  logic [XLEN-1:0]   wb_result,
    output logic              ex_valid,
    output logic [XLEN-1:0]   alu_operand_a,
    output logic [XLEN-1:0]   alu_operand_b,
    output logic [3:0]        alu_op,
    output logic [XLEN-1:0]   ex_store_data,
    output logic [XLEN-1:0]   ex_pc,
    output logic [REG_AW-1:0] ex_rd_addr,
    output logic              ex_reg_write
);

    id_ex_t          ex_q, ex_d;
    logic [XLEN-1:0] rs1_fwd, rs2_fwd;
    fwd_sel_t        unused_rs1_sel, unused_rs2_sel;

    assign id_ready = !ex_stall;

    // flush is applied last so it beats both capture and stall
    always_comb begin
        ex_d = ex_q;
        if (id_ready)
            ex_d = '{valid: id_valid, pc: id_pc, rs1_addr: id_rs1_addr, rs2_addr: id_rs2_addr,
                     rs1_data: id_rs1_data, rs2_data: id_rs2_data, imm: id_imm,
                     alu_op: alu_op_t'(id_alu_op), src_a_sel: id_src_a_sel,
                     src_b_sel: id_src_b_sel, rd_addr: id_rd_addr, reg_write: id_reg_write};
        if (flush)
            ex_d.valid = 1'b0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            ex_q <= '0;
        else
            ex_q <= ex_d;
    end

    riscv_fwd_unit u_fwd_rs1 (
        .addr(ex_q.rs1_addr), .reg_data(ex_q.rs1_data),
        .mem_rd_addr(mem_rd_addr), .mem_reg_write(mem_reg_write), .mem_result(mem_result),
        .wb_rd_addr(wb_rd_addr), .wb_reg_write(wb_reg_write), .wb_result(wb_result),
        .sel(unused_rs1_sel), .value(rs1_fwd)
    );

    riscv_fwd_unit u_fwd_rs2 (
        .addr(ex_q.rs2_addr), .reg_data(ex_q.rs2_data),
        .mem_rd_addr(mem_rd_addr), .mem_reg_write(mem_reg_write), .mem_result(mem_result),
        .wb_rd_addr(wb_rd_addr), .wb_reg_write(wb_reg_write), .wb_result(wb_result),
        .sel(unused_rs2_sel), .value(rs2_fwd)
    );

    assign alu_operand_a = (ex_q.src_a_sel == SRC_A_RS1) ? rs1_fwd :
                           (ex_q.src_a_sel == SRC_A_PC)  ? ex_q.pc : '0;
    assign alu_operand_b = ex_q.src_b_sel ? ex_q.imm : rs2_fwd;
    assign alu_op        = ex_q.alu_op;
    assign ex_store_data = rs2_fwd;
    assign ex_valid      = ex_q.valid;
    assign ex_pc         = ex_q.pc;
    assign ex_rd_addr    = ex_q.rd_addr;
    assign ex_reg_write  = ex_q.reg_write & ex_q.valid;

endmodule

// File: tb/tb_riscv_id_ex_stage.sv
// tb_riscv_id_ex_stage: directed vectors against a behavioural model of the ID/EX stage,
// checked every negedge, plus hand-computed literal expectations.
module tb_riscv_id_ex_stage;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        id_valid, id_ready;
    logic [31:0] id_pc, id_rs1_data, id_rs2_data, id_imm;
    logic [4:0]  id_rs1_addr, id_rs2_addr, id_rd_addr;
    logic [3:0]  id_alu_op;
    logic [1:0]  id_src_a_sel;
    logic        id_src_b_sel, id_reg_write;
    logic        flush, ex_stall;
    logic [4:0]  mem_rd_addr, wb_rd_addr;
    logic        mem_reg_write, wb_reg_write;
    logic [31:0] mem_result, wb_result;
    logic        ex_valid, ex_reg_write;
    logic [31:0] alu_operand_a, alu_operand_b, ex_store_data, ex_pc;
    logic [3:0]  alu_op;
    logic [4:0]  ex_rd_addr;

    int vectors = 0;
    int miscompares = 0;
    bit fwd_on;

    riscv_id_ex_stage dut (
        .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_ready(id_ready),
        .id_pc(id_pc), .id_rs1_addr(id_rs1_addr), .id_rs2_addr(id_rs2_addr),
        .id_rs1_data(id_rs1_data), .id_rs2_data(id_rs2_data), .id_imm(id_imm),
        .id_alu_op(id_alu_op), .id_src_a_sel(id_src_a_sel), .id_src_b_sel(id_src_b_sel),
        .id_rd_addr(id_rd_addr), .id_reg_write(id_reg_write), .flush(flush), .ex_stall(ex_stall),
        .mem_rd_addr(mem_rd_addr), .mem_reg_write(mem_reg_write), .mem_result(mem_result),
        .wb_rd_addr(wb_rd_addr), .wb_reg_write(wb_reg_write), .wb_result(wb_result),
        .ex_valid(ex_valid), .alu_operand_a(alu_operand_a), .alu_operand_b(alu_operand_b),
        .alu_op(alu_op), .ex_store_data(ex_store_data), .ex_pc(ex_pc),
        .ex_rd_addr(ex_rd_addr), .ex_reg_write(ex_reg_write)
    );

    always #5 clk = ~clk;

    // Model of the instruction currently held in EX
    logic        m_valid, m_rw, m_bsel;
    logic [31:0] m_pc, m_d1, m_d2, m_imm;
    logic [4:0]  m_a1, m_a2, m_rd;
    logic [3:0]  m_op;
    logic [1:0]  m_asel;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            {m_valid, m_rw, m_bsel, m_pc, m_d1, m_d2, m_imm, m_a1, m_a2, m_rd, m_op, m_asel} <= '0;
        end else begin
            if (!ex_stall) begin
                m_valid <= id_valid; m_pc <= id_pc; m_a1 <= id_rs1_addr; m_a2 <= id_rs2_addr;
                m_d1 <= id_rs1_data; m_d2 <= id_rs2_data; m_imm <= id_imm; m_op <= id_alu_op;
                m_asel <= id_src_a_sel; m_bsel <= id_src_b_sel; m_rd <= id_rd_addr; m_rw <= id_reg_write;
            end
            if (flush) m_valid <= 1'b0;
        end
    end

    function automatic logic [31:0] fwd(input logic [4:0] a, input logic [31:0] d);
        if (fwd_on && a != 0 && mem_reg_write && mem_rd_addr == a) return mem_result;
        if (fwd_on && a != 0 && wb_reg_write && wb_rd_addr == a) return wb_result;
        return d;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        chk("m_id_ready", 32'(id_ready), 32'(!ex_stall));
        chk("m_ex_valid", 32'(ex_valid), 32'(m_valid));
        chk("m_ex_reg_write", 32'(ex_reg_write), 32'(m_rw && m_valid));
        chk("m_alu_op", 32'(alu_op), 32'(m_op));
        chk("m_ex_pc", ex_pc, m_pc);
        chk("m_ex_rd_addr", 32'(ex_rd_addr), 32'(m_rd));
        chk("m_operand_a", alu_operand_a,
            m_asel == 2'd0 ? fwd(m_a1, m_d1) : m_asel == 2'd1 ? m_pc : 32'd0);
        chk("m_operand_b", alu_operand_b, m_bsel ? m_imm : fwd(m_a2, m_d2));
        chk("m_store_data", ex_store_data, fwd(m_a2, m_d2));
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_id(input logic [31:0] pc, input logic [4:0] a1, input logic [4:0] a2,
                          input logic [31:0] d1, input logic [31:0] d2, input logic [31:0] imm,
                          input logic [3:0] op, input logic [1:0] asel, input logic bsel,
                          input logic [4:0] rd, input logic rw);
        id_pc = pc; id_rs1_addr = a1; id_rs2_addr = a2; id_rs1_data = d1; id_rs2_data = d2;
        id_imm = imm; id_alu_op = op; id_src_a_sel = asel; id_src_b_sel = bsel;
        id_rd_addr = rd; id_reg_write = rw;
    endtask

    initial begin
`ifdef RISCV_EX_FORWARD_EN
        fwd_on = 1'b1;
`else
        fwd_on = 1'b0;
`endif
        rst_n = 1'b0; id_valid = 1'b0; flush = 1'b0; ex_stall = 1'b0;
        set_id(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        mem_rd_addr = 0; mem_reg_write = 0; mem_result = 0;
        wb_rd_addr = 0; wb_reg_write = 0; wb_result = 0;
        repeat (2) tick();
        chk("reset_valid", 32'(ex_valid), 0);
        chk("reset_ready", 32'(id_ready), 1);
        rst_n = 1'b1;

        // ADD x1=5, x2=7
        set_id(32'h40, 1, 2, 5, 7, 0, 4'd0, 2'b00, 1'b0, 4, 1'b1);
        id_valid = 1'b1;
        tick();
        id_valid = 1'b0;
        chk("add_a", alu_operand_a, 5);
        chk("add_b", alu_operand_b, 7);
        chk("add_op", 32'(alu_op), 0);
        chk("add_valid", 32'(ex_valid), 1);
        chk("add_rw", 32'(ex_reg_write), 1);
        chk("add_pc", ex_pc, 32'h40);
        tick();
        chk("bubble_valid", 32'(ex_valid), 0);
        chk("bubble_rw", 32'(ex_reg_write), 0);

        // MEM beats WB, then WB alone, then neither
        set_id(32'h44, 3, 5, 32'h2222, 32'h55, 0, 4'd1, 2'b00, 1'b0, 6, 1'b1);
        id_valid = 1'b1;
        tick();
        ex_stall = 1'b1;
        mem_rd_addr = 3; mem_reg_write = 1; mem_result = 32'hDEAD;
        wb_rd_addr = 3; wb_reg_write = 1; wb_result = 32'h1111;
        #1 chk("fwd_mem", alu_operand_a, fwd_on ? 32'hDEAD : 32'h2222);
        mem_reg_write = 0;
        #1 chk("fwd_wb", alu_operand_a, fwd_on ? 32'h1111 : 32'h2222);
        wb_reg_write = 0;
        #1 chk("fwd_none", alu_operand_a, 32'h2222);
        chk("sub_op", 32'(alu_op), 1);
        tick();

        // x0 never forwarded
        ex_stall = 1'b0;
        set_id(32'h48, 1, 0, 32'h10, 0, 0, 4'd0, 2'b00, 1'b0, 7, 1'b1);
        mem_rd_addr = 0; mem_reg_write = 1; mem_result = 32'hFFFF_FFFF;
        wb_rd_addr = 0; wb_reg_write = 1; wb_result = 32'hAAAA;
        tick();
        ex_stall = 1'b1;
        #1 chk("x0_b", alu_operand_b, 0);
        chk("x0_store", ex_store_data, 0);

        // Store data forwarded while operand B takes the immediate
        ex_stall = 1'b0;
        set_id(32'h4C, 1, 9, 32'h10, 32'h99, 32'h123, 4'd0, 2'b00, 1'b1, 0, 1'b0);
        mem_rd_addr = 9; mem_reg_write = 1; mem_result = 32'hBEEF; wb_reg_write = 0;
        tick();
        ex_stall = 1'b1;
        chk("imm_b", alu_operand_b, 32'h123);
        chk("store_fwd", ex_store_data, fwd_on ? 32'hBEEF : 32'h99);
        chk("store_rw", 32'(ex_reg_write), 0);

        // Stall 3 cycles with new ID data, then flush under stall
        mem_reg_write = 0;
        for (int i = 0; i < 3; i++) begin
            set_id(32'h800 + 32'(i), 2, 3, 1, 2, 3, 4'd4, 2'b01, 1'b0, 8, 1'b1);
            tick();
            chk("stall_ready", 32'(id_ready), 0);
            chk("stall_pc", ex_pc, 32'h4C);
            chk("stall_b", alu_operand_b, 32'h123);
        end
        flush = 1'b1;
        tick();
        flush = 1'b0;
        chk("flush_valid", 32'(ex_valid), 0);
        chk("flush_rw", 32'(ex_reg_write), 0);
        chk("flush_pc_held", ex_pc, 32'h4C);

        // Flush beats capture
        ex_stall = 1'b0;
        flush = 1'b1;
        tick();
        flush = 1'b0;
        id_valid = 1'b0;
        chk("flush_cap_valid", 32'(ex_valid), 0);

        // LUI / AUIPC / reserved select
        id_valid = 1'b1;
        set_id(32'h200, 1, 2, 32'h77, 32'h88, 32'h12345000, 4'd0, 2'b10, 1'b1, 10, 1'b1);
        tick();
        chk("lui_a", alu_operand_a, 0);
        chk("lui_b", alu_operand_b, 32'h12345000);
        set_id(32'h100, 1, 2, 32'h77, 32'h88, 32'h1000, 4'd0, 2'b01, 1'b1, 10, 1'b1);
        tick();
        chk("auipc_a", alu_operand_a, 32'h100);
        set_id(32'h104, 1, 2, 32'h77, 32'h88, 32'h1000, 4'd0, 2'b11, 1'b1, 10, 1'b1);
        tick();
        chk("rsvd_a", alu_operand_a, 0);

        // Async reset mid-transfer
        set_id(32'h300, 1, 2, 32'h5, 32'h6, 0, 4'd9, 2'b00, 1'b0, 11, 1'b1);
        tick();
        chk("sra_op", 32'(alu_op), 9);
        #2 rst_n = 1'b0;
        #1 chk("areset_valid", 32'(ex_valid), 0);
        chk("areset_op", 32'(alu_op), 0);
        chk("areset_rw", 32'(ex_reg_write), 0);
        chk("areset_ready", 32'(id_ready), 1);
        chk("areset_a", alu_operand_a, 0);
        id_valid = 1'b0;
        tick();
        rst_n = 1'b1;
        repeat (2) tick();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
